// File: rtl/vram_writer.sv
// Write-side VRAM master: turns plot/fill cell commands into masked 16-bit word writes.
// Define VRAM_WR_FIFO_EN to put a FIFO_DEPTH-entry command FIFO in front of the FSM.
module vram_writer #(
  parameter int unsigned BASE_ADDR  = 1,
  parameter int unsigned H_CELLS    = 160,
  parameter int unsigned V_CELLS    = 60,
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_fill,
  input  logic [7:0]            cmd_col,
  input  logic [5:0]            cmd_row,
  input  logic [5:0]            cmd_color,
  output logic                  busy,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  vram_wen,
  output logic [ADDR_WIDTH-1:0] vram_waddr,
  output logic [15:0]           vram_wdata,
  output logic [15:0]           vram_wmask
);

  localparam int unsigned WORDS_PER_ROW = H_CELLS / 2;
  localparam int unsigned FILL_WORDS    = WORDS_PER_ROW * V_CELLS;

  typedef struct packed {
    logic       fill;
    logic [7:0] col;
    logic [5:0] row;
    logic [5:0] color;
  } cmd_t;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("vram_writer: FIFO_DEPTH must be a power of two >= 2");
  end

  state_t                r_state;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [15:0]           r_wdata;
  logic [15:0]           r_wmask;

  cmd_t                  w_in_cmd;
  cmd_t                  w_cmd;
  logic                  w_cmd_valid;
  logic                  w_take;
  logic                  w_in_range;
  logic                  w_fill_last;
  logic [ADDR_WIDTH-1:0] w_plot_addr;
  logic [15:0]           w_wdata;

  assign w_in_cmd = '{fill: cmd_fill, col: cmd_col, row: cmd_row, color: cmd_color};

`ifdef VRAM_WR_FIFO_EN
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

  cmd_t             r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;

  assign cmd_ready   = (r_count != (PTR_W+1)'(FIFO_DEPTH));
  assign w_push      = cmd_valid && cmd_ready;
  assign w_cmd_valid = (r_count != '0);
  assign w_cmd       = r_fifo[r_rd_ptr];

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= w_in_cmd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_take) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_take)      r_count <= r_count + (PTR_W+1)'(1);
      else if (!w_push && w_take) r_count <= r_count - (PTR_W+1)'(1);
    end
  end
`else
  assign cmd_ready   = !r_busy;
  assign w_cmd_valid = cmd_valid;
  assign w_cmd       = w_in_cmd;
`endif

  assign w_take      = w_cmd_valid && !r_busy;
  assign w_in_range  = (32'(w_cmd.col) < H_CELLS) && (32'(w_cmd.row) < V_CELLS);
  assign w_plot_addr = ADDR_WIDTH'(BASE_ADDR)
                     + ADDR_WIDTH'(WORDS_PER_ROW) * ADDR_WIDTH'(w_cmd.row)
                     + ADDR_WIDTH'(w_cmd.col[7:1]);
  assign w_wdata     = {2'b00, w_cmd.color, 2'b00, w_cmd.color};
  assign w_fill_last = (r_waddr == ADDR_WIDTH'(BASE_ADDR + FILL_WORDS - 1));

  // Command FSM: plots complete in IDLE, fills stream one word per cycle in FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_wen   <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else begin
      r_wen <= 1'b0;
      if (err_clr) r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            if (w_cmd.fill) begin
              r_state <= S_FILL;
              r_busy  <= 1'b1;
              r_wen   <= 1'b1;
              r_waddr <= ADDR_WIDTH'(BASE_ADDR);
              r_wdata <= w_wdata;
              r_wmask <= 16'hFFFF;
            end else if (w_in_range) begin
              r_wen   <= 1'b1;
              r_waddr <= w_plot_addr;
              r_wdata <= w_wdata;
              r_wmask <= w_cmd.col[0] ? 16'h00FF : 16'hFF00;
            end else begin
              r_err <= 1'b1;  // set wins over a coincident err_clr
            end
          end
        end
        S_FILL: begin
          if (w_fill_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_wen   <= 1'b1;
            r_waddr <= r_waddr + ADDR_WIDTH'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign err        = r_err;
  assign vram_wen   = r_wen;
  assign vram_waddr = r_waddr;
  assign vram_wdata = r_wdata;
  assign vram_wmask = r_wmask;

endmodule

// File: tb/tb_vram_writer.sv
// Directed self-checking bench for vram_writer (plot, range errors, fill, reset, FIFO build).
module tb_vram_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_fill;
  logic [7:0]  cmd_col;
  logic [5:0]  cmd_row;
  logic [5:0]  cmd_color;
  logic        busy;
  logic        err;
  logic        err_clr;
  logic        vram_wen;
  logic [13:0] vram_waddr;
  logic [15:0] vram_wdata;
  logic [15:0] vram_wmask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vram_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_fill   (cmd_fill),
    .cmd_col    (cmd_col),
    .cmd_row    (cmd_row),
    .cmd_color  (cmd_color),
    .busy       (busy),
    .err        (err),
    .err_clr    (err_clr),
    .vram_wen   (vram_wen),
    .vram_waddr (vram_waddr),
    .vram_wdata (vram_wdata),
    .vram_wmask (vram_wmask)
  );

  // Present one plot for exactly one accepting edge (caller ensures cmd_ready).
  task automatic send_plot(input logic [7:0] col, input logic [5:0] row, input logic [5:0] color);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_fill = 1'b0; cmd_col = col; cmd_row = row; cmd_color = color;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_fill = 1'b0; cmd_col = '0; cmd_row = '0;
    cmd_color = '0; err_clr = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (vram_wen !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %b expected 0", vram_wen); end
    n_checks++; if (vram_waddr !== 14'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", vram_waddr); end
    n_checks++; if (vram_wdata !== 16'h0000) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0000", vram_wdata); end
    n_checks++; if (vram_wmask !== 16'h0000) begin n_fail++; $display("FAIL reset_wmask: got %h expected 0000", vram_wmask); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_busy_err: got %b%b expected 00", busy, err); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_plot_origin;
    send_plot(8'd0, 6'd0, 6'h3F);
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b1) begin n_fail++; $display("FAIL origin_wen: got %b expected 1", vram_wen); end
    n_checks++; if (vram_waddr !== 14'd1) begin n_fail++; $display("FAIL origin_addr: got %0d expected 1", vram_waddr); end
    n_checks++; if (vram_wdata !== 16'h3F3F) begin n_fail++; $display("FAIL origin_data: got %h expected 3f3f", vram_wdata); end
    n_checks++; if (vram_wmask !== 16'hFF00) begin n_fail++; $display("FAIL origin_mask: got %h expected ff00", vram_wmask); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL origin_err: got %b expected 0", err); end
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b0) begin n_fail++; $display("FAIL origin_single_pulse: got %b expected 0", vram_wen); end
  endtask

  task automatic test_plot_corner;
    send_plot(8'd159, 6'd59, 6'h15);
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b1 || vram_waddr !== 14'd4800) begin n_fail++; $display("FAIL corner_addr: got wen=%b addr=%0d expected wen=1 addr=4800", vram_wen, vram_waddr); end
    n_checks++; if (vram_wdata !== 16'h1515 || vram_wmask !== 16'h00FF) begin n_fail++; $display("FAIL corner_data_mask: got %h/%h expected 1515/00ff", vram_wdata, vram_wmask); end
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b0) begin n_fail++; $display("FAIL corner_single_pulse: got %b expected 0", vram_wen); end
  endtask

  task automatic test_out_of_range;
    send_plot(8'd160, 6'd0, 6'h3F);
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b0) begin n_fail++; $display("FAIL oor_col_wen: got %b expected 0", vram_wen); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL oor_col_err: got %b expected 1", err); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL oor_ready: got %b expected 1", cmd_ready); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b expected 0", err); end
    send_plot(8'd5, 6'd60, 6'h01);
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL oor_row: got wen=%b err=%b expected wen=0 err=1", vram_wen, err); end
    // err_clr coinciding with a new error: the new error must stick
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_fill = 1'b0; cmd_col = 8'd200; cmd_row = 6'd0;
    @(posedge clk); #1;
    cmd_valid = 1'b0; err_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== 1'b1 || vram_wen !== 1'b0) begin n_fail++; $display("FAIL err_set_wins: got err=%b wen=%b expected err=1 wen=0", err, vram_wen); end
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_fill = 1'b0; cmd_col = 8'd4; cmd_row = 6'd1; cmd_color = 6'h01;
    @(posedge clk); #1;
    cmd_col = 8'd5; cmd_row = 6'd1; cmd_color = 6'h02;
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b1 || vram_waddr !== 14'd83 || vram_wmask !== 16'hFF00 || vram_wdata !== 16'h0101) begin n_fail++; $display("FAIL b2b_0: got %b %0d %h %h expected 1 83 ff00 0101", vram_wen, vram_waddr, vram_wmask, vram_wdata); end
    @(posedge clk); #1;
    cmd_col = 8'd10; cmd_row = 6'd2; cmd_color = 6'h30;
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b1 || vram_waddr !== 14'd83 || vram_wmask !== 16'h00FF || vram_wdata !== 16'h0202) begin n_fail++; $display("FAIL b2b_1: got %b %0d %h %h expected 1 83 00ff 0202", vram_wen, vram_waddr, vram_wmask, vram_wdata); end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b1 || vram_waddr !== 14'd166 || vram_wmask !== 16'hFF00 || vram_wdata !== 16'h3030) begin n_fail++; $display("FAIL b2b_2: got %b %0d %h %h expected 1 166 ff00 3030", vram_wen, vram_waddr, vram_wmask, vram_wdata); end
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", vram_wen); end
  endtask

  task automatic test_fill;
    int n_wen = 0, n_busy = 0, n_nready = 0, n_bad_addr = 0, n_bad_dm = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_col = 8'd7; cmd_row = 6'd3; cmd_color = 6'h05;
    @(posedge clk); #1;
    // A plot held valid through the fill must wait until the fill ends.
    cmd_fill = 1'b0; cmd_col = 8'd2; cmd_row = 6'd0; cmd_color = 6'h2A;
    for (int k = 1; k <= 4800; k++) begin
      @(negedge clk);
      if (vram_wen === 1'b1) n_wen++;
      if (busy === 1'b1) n_busy++;
      if (cmd_ready === 1'b0) n_nready++;
      if (vram_waddr !== 14'(k)) n_bad_addr++;
      if (vram_wdata !== 16'h0505 || vram_wmask !== 16'hFFFF) n_bad_dm++;
    end
    n_checks++; if (n_wen != 4800) begin n_fail++; $display("FAIL fill_wen_count: got %0d expected 4800", n_wen); end
    n_checks++; if (n_busy != 4800) begin n_fail++; $display("FAIL fill_busy_count: got %0d expected 4800", n_busy); end
    n_checks++; if (n_nready != 4800) begin n_fail++; $display("FAIL fill_notready_count: got %0d expected 4800", n_nready); end
    n_checks++; if (n_bad_addr != 0) begin n_fail++; $display("FAIL fill_addr_seq: got %0d bad cycles expected 0", n_bad_addr); end
    n_checks++; if (n_bad_dm != 0) begin n_fail++; $display("FAIL fill_data_mask: got %0d bad cycles expected 0", n_bad_dm); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || vram_wen !== 1'b0 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL fill_end: got busy=%b wen=%b ready=%b expected 0 0 1", busy, vram_wen, cmd_ready); end
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b1 || vram_waddr !== 14'd2 || vram_wmask !== 16'hFF00 || vram_wdata !== 16'h2A2A) begin n_fail++; $display("FAIL fill_held_plot: got %b %0d %h %h expected 1 2 ff00 2a2a", vram_wen, vram_waddr, vram_wmask, vram_wdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL fill_err: got %b expected 0", err); end
  endtask

  task automatic test_reset_mid_fill;
    int n_wen = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_color = 6'h11;
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (vram_wen === 1'b1) n_wen++;
    end
    n_checks++; if (n_wen != 100 || vram_waddr !== 14'd100) begin n_fail++; $display("FAIL midfill_progress: got %0d writes addr %0d expected 100 100", n_wen, vram_waddr); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (vram_wen !== 1'b0 || busy !== 1'b0 || vram_waddr !== 14'd0) begin n_fail++; $display("FAIL midfill_async_clear: got wen=%b busy=%b addr=%0d expected 0 0 0", vram_wen, busy, vram_waddr); end
    @(negedge clk) rst_n = 1'b1;
    send_plot(8'd1, 6'd0, 6'h0C);
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b1 || vram_waddr !== 14'd1 || vram_wmask !== 16'h00FF || vram_wdata !== 16'h0C0C) begin n_fail++; $display("FAIL post_reset_plot: got %b %0d %h %h expected 1 1 00ff 0c0c", vram_wen, vram_waddr, vram_wmask, vram_wdata); end
    @(negedge clk);
    n_checks++; if (vram_wen !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got wen=%b busy=%b expected 0 0", vram_wen, busy); end
  endtask

`ifdef VRAM_WR_FIFO_EN
  task automatic test_fifo;
    logic [7:0]  cols   [5];
    logic [5:0]  rows   [5];
    logic [13:0] e_addr [5];
    logic [15:0] e_mask [5];
    logic [15:0] e_data [5];
    logic [13:0] g_addr [5];
    logic [15:0] g_mask [5];
    logic [15:0] g_data [5];
    int          g_cyc  [5];
    int n_fill = 0, n_plot = 0, last_fill_cyc = -1;
    logic drop_next = 1'b0;
    cols   = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    rows   = '{6'd0, 6'd0, 6'd1, 6'd1, 6'd0};
    e_addr = '{14'd1, 14'd1, 14'd82, 14'd82, 14'd3};
    e_mask = '{16'hFF00, 16'h00FF, 16'hFF00, 16'h00FF, 16'hFF00};
    e_data = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505};
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_fill = 1'b1; cmd_color = 6'h05;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      cmd_fill = 1'b0; cmd_col = cols[i]; cmd_row = rows[i]; cmd_color = 6'(i + 1);
      @(negedge clk);
      n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL fifo_accept_%0d: got ready=%b expected 1", i, cmd_ready); end
      @(posedge clk); #1;
    end
    cmd_col = cols[4]; cmd_row = rows[4]; cmd_color = 6'h05;
    for (int c = 0; c < 5200 && n_plot < 5; c++) begin
      @(negedge clk);
      if (c == 0) begin
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fifo_full_hold: got ready=%b expected 0", cmd_ready); end
      end
      if (drop_next) begin cmd_valid = 1'b0; drop_next = 1'b0; end
      if (vram_wen === 1'b1 && vram_wmask === 16'hFFFF) begin
        n_fill++;
        if (vram_waddr === 14'd4800) last_fill_cyc = c;
      end else if (vram_wen === 1'b1) begin
        g_addr[n_plot] = vram_waddr; g_mask[n_plot] = vram_wmask;
        g_data[n_plot] = vram_wdata; g_cyc[n_plot] = c; n_plot++;
      end
      if (cmd_valid && cmd_ready) drop_next = 1'b1;
    end
    n_checks++; if (n_fill != 4800) begin n_fail++; $display("FAIL fifo_fill_count: got %0d expected 4800", n_fill); end
    n_checks++; if (n_plot != 5) begin n_fail++; $display("FAIL fifo_plot_count: got %0d expected 5", n_plot); end
    for (int i = 0; i < n_plot; i++) begin
      n_checks++;
      if (g_addr[i] !== e_addr[i] || g_mask[i] !== e_mask[i] || g_data[i] !== e_data[i]) begin
        n_fail++; $display("FAIL fifo_plot_%0d: got %0d %h %h expected %0d %h %h", i, g_addr[i], g_mask[i], g_data[i], e_addr[i], e_mask[i], e_data[i]);
      end
    end
    if (n_plot > 0) begin
      n_checks++; if (last_fill_cyc < 0 || g_cyc[0] <= last_fill_cyc || g_cyc[0] > last_fill_cyc + 3) begin n_fail++; $display("FAIL fifo_after_fill: got first plot cycle %0d, fill end %0d expected within 3 after", g_cyc[0], last_fill_cyc); end
    end
  endtask
`endif

  initial begin
    test_reset;
`ifdef VRAM_WR_FIFO_EN
    test_fifo;
`else
    test_plot_origin;
    test_plot_corner;
    test_out_of_range;
    test_back_to_back;
    test_fill;
    test_reset_mid_fill;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
